// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button conditioner: FSM encodings and default
// cycle constants (125 MHz board clock) reused by the blinky logic.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } btn_state_e;

  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_DEBOUNCE_CYCLES   = 1_250_000;
  localparam int DEF_LONG_PRESS_CYCLES = 125_000_000;

endpackage

// File: rtl/btn_debounce_sync.sv
// Generic multi-flop synchroniser for asynchronous board inputs.
module sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronise, debounce, and derive press/release/long-press pulses.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_PRESS_CYCLES - 1);

  function automatic logic [DW-1:0] sat_inc_deb(input logic [DW-1:0] v);
    return (v == {DW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [LW-1:0] sat_inc_long(input logic [LW-1:0] v);
    return (v == {LW{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic          btn_sync;
  logic [DW-1:0] deb_cnt_p0;
  logic          deb_level_p0;
  logic          rise_p0;
  logic          fall_p0;
  btn_state_e    state_q, state_d;
  logic [LW-1:0] long_cnt_q, long_cnt_d;
  logic          long_d;

  sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (btn_sync)
  );

  // Stage p0: debounce. deb_level_p0 is the accepted level one cycle ahead of
  // btn_level, so level and edge pulses can be registered together below.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_p0   <= '0;
      deb_level_p0 <= 1'b0;
    end else if (btn_sync == deb_level_p0) begin
      deb_cnt_p0 <= '0;
    end else if (deb_cnt_p0 == DEB_LAST) begin
      deb_level_p0 <= ~deb_level_p0;
      deb_cnt_p0   <= '0;
    end else begin
      deb_cnt_p0 <= sat_inc_deb(deb_cnt_p0);
    end
  end

  assign rise_p0 = deb_level_p0 & ~btn_level;
  assign fall_p0 = ~deb_level_p0 & btn_level;

  always_comb begin
    state_d    = state_q;
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    unique case (state_q)
      RELEASED: begin
        long_cnt_d = '0;
        if (rise_p0) state_d = PRESSED;
      end
      PRESSED: begin
        if (fall_p0) begin
          state_d    = RELEASED;
          long_cnt_d = '0;
        end else if (long_cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          long_cnt_d = sat_inc_long(long_cnt_q);
        end
      end
      LONG_HELD: begin
        if (fall_p0) begin
          state_d    = RELEASED;
          long_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RELEASED;
        long_cnt_d = '0;
      end
    endcase
  end

  // Stage p1: registered level, edge pulses and long-press FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      state_q     <= RELEASED;
      long_cnt_q  <= '0;
    end else begin
      btn_level   <= deb_level_p0;
      btn_press   <= rise_p0;
      btn_release <= fall_p0;
      btn_long    <= long_d;
      state_q     <= state_d;
      long_cnt_q  <= long_cnt_d;
    end
  end

endmodule
